// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e : FSM encoding (IDLE / RUN / HALT)
//   - IMW_DEF       : default instruction-memory address width (matches PC width)
//   - IW_DEF        : default instruction width (matches register-file width)
//   - HALT_OP       : opcode that stops fetching when INSTR_FETCH_HALT_EN is set
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int unsigned IMW_DEF = 4;
  localparam int unsigned IW_DEF  = 32;

  // The HALT opcode is the all-ones word.
  localparam logic [IW_DEF-1:0] HALT_OP = {IW_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bus bundle between the PC, the fetch stage and decode.
//   PC side     : pc_valid, pc_in (to fetch), pc_ready (from fetch)
//   Redirect    : flush (to fetch)
//   Decode side : out_ready (to fetch), out_valid, instr_out, pc_out (from fetch)
// Modports:
//   master : the surrounding pipeline (PC + decode) that drives fetch
//   slave  : the fetch stage itself
// -----------------------------------------------------------------------------
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned IMW = IMW_DEF,
  parameter int unsigned IW  = IW_DEF
) ();

  logic           pc_valid;
  logic [IMW-1:0] pc_in;
  logic           pc_ready;
  logic           flush;
  logic           out_ready;
  logic           out_valid;
  logic [IW-1:0]  instr_out;
  logic [IMW-1:0] pc_out;

  modport master (
    output pc_valid, pc_in, flush, out_ready,
    input  pc_ready, out_valid, instr_out, pc_out
  );

  modport slave (
    input  pc_valid, pc_in, flush, out_ready,
    output pc_ready, out_valid, instr_out, pc_out
  );

endinterface : instr_fetch_if

// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// Instruction memory: 2^AW words of DW bits, one write port, synchronous read.
// Contents are not reset, so a program survives a restart of the fetch stage.
// Ports:
//   clk   in  clock
//   we    in  write strobe
//   waddr in  write word address
//   wdata in  write data
//   raddr in  read word address (registered read)
//   rdata out word at raddr as sampled on the previous clock edge
// -----------------------------------------------------------------------------
module instr_mem
  import instr_fetch_pkg::*;
#(
  parameter int unsigned AW = IMW_DEF,
  parameter int unsigned DW = IW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Program-load write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule : instr_mem

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage. Accepts fetch addresses from the PC, reads the local
// instruction memory and hands (instr, pc) pairs to decode through a two-stage
// pipeline (S1 = memory read in flight, S2 = output register) with full
// backpressure and flush. Also owns the program-load path, active only in IDLE.
//
// Ports:
//   clk        in   rising-edge clock
//   start      in   synchronous active-high reset (memory is not cleared)
//   run        in   pulse: IDLE -> RUN
//   load_en    in   program-load write strobe, honoured only in IDLE
//   load_addr  in   program-load word address
//   load_data  in   program-load word
//   bus        slave modport of instr_fetch_if (PC handshake, flush, decode side)
//   halted     out  fetch stopped on the HALT opcode
//
// Configuration macro: INSTR_FETCH_HALT_EN
//   defined   : an all-ones word moving S1->S2 is delivered, then fetch halts
//               until start.
//   undefined : no halting; all-ones is ordinary data and halted stays 0.
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned IMW = IMW_DEF,
  parameter int unsigned IW  = IW_DEF
) (
  input  logic           clk,
  input  logic           start,
  input  logic           run,
  input  logic           load_en,
  input  logic [IMW-1:0] load_addr,
  input  logic [IW-1:0]  load_data,
  instr_fetch_if.slave   bus,
  output logic           halted
);

  fetch_state_e   state_r;
  fetch_state_e   state_next_s;

  logic           v1_r;
  logic [IMW-1:0] pc1_r;
  logic           v2_r;
  logic [IMW-1:0] pc2_r;
  logic [IW-1:0]  instr2_r;
  logic           halted_r;

  logic           adv1_s;
  logic           adv2_s;
  logic           pc_ready_s;
  logic           accept_s;
  logic           s1_to_s2_s;
  logic           halt_hit_s;
  logic           mem_we_s;
  logic [IMW-1:0] mem_raddr_s;
  logic [IW-1:0]  mem_rdata_s;

  // Pipeline advance terms, PC handshake and memory port control.
  always_comb begin
    adv2_s      = ~v2_r | bus.out_ready;
    adv1_s      = ~v1_r | adv2_s;
    pc_ready_s  = (state_r == ST_RUN) & adv1_s & ~bus.flush;
    accept_s    = bus.pc_valid & pc_ready_s;
    s1_to_s2_s  = v1_r & adv2_s;
    // Re-reading pc1 while S1 is stalled keeps the registered read data stable.
    mem_raddr_s = accept_s ? bus.pc_in : pc1_r;
    mem_we_s    = (state_r == ST_IDLE) & load_en & ~start;
  end

`ifdef INSTR_FETCH_HALT_EN
  // HALT opcode leaving S1 stops fetching; a same-cycle flush discards it instead.
  always_comb begin
    halt_hit_s = s1_to_s2_s & ~bus.flush & (mem_rdata_s == IW'(HALT_OP));
  end
`else
  assign halt_hit_s = 1'b0;
`endif

  // Next-state selection for the IDLE/RUN/HALT controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_hit_s) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Controller state register and registered halted flag.
  always_ff @(posedge clk) begin
    if (start) begin
      state_r  <= ST_IDLE;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == ST_HALT);
    end
  end

  // S1/S2 pipeline registers.
  always_ff @(posedge clk) begin
    if (start) begin
      v1_r     <= 1'b0;
      pc1_r    <= {IMW{1'b0}};
      v2_r     <= 1'b0;
      pc2_r    <= {IMW{1'b0}};
      instr2_r <= {IW{1'b0}};
    end else if (bus.flush) begin
      // Flush wins over out_ready: whatever sits in S2 is dropped.
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      if (adv2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          instr2_r <= mem_rdata_s;
          pc2_r    <= pc1_r;
        end
      end
      if (accept_s) begin
        pc1_r <= bus.pc_in;
      end
      // A halt clears S1 even if an address was handshaken in the same cycle.
      if (halt_hit_s) begin
        v1_r <= 1'b0;
      end else if (accept_s) begin
        v1_r <= 1'b1;
      end else if (s1_to_s2_s) begin
        v1_r <= 1'b0;
      end
    end
  end

  instr_mem #(
    .AW (IMW),
    .DW (IW)
  ) u_instr_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (mem_raddr_s),
    .rdata (mem_rdata_s)
  );

  assign bus.pc_ready  = pc_ready_s;
  assign bus.out_valid = v2_r;
  assign bus.instr_out = instr2_r;
  assign bus.pc_out    = pc2_r;
  assign halted        = halted_r;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Accepted fetches push their expected
// (pc, instr) pair into a scoreboard queue; a monitor pops and compares every
// word decode consumes. Cycle-specific behaviour (latency, stall, flush, start,
// halt) is checked directly against hand-computed values.
// Honours INSTR_FETCH_HALT_EN to select the expected halt behaviour.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int unsigned IMW = IMW_DEF;
  localparam int unsigned IW  = IW_DEF;
`ifdef INSTR_FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IMW-1:0] pc;
    logic [IW-1:0]  instr;
  } exp_t;

  logic           clk = 1'b0;
  logic           start;
  logic           run;
  logic           load_en;
  logic [IMW-1:0] load_addr;
  logic [IW-1:0]  load_data;
  logic           halted;

  exp_t           sb_q[$];
  logic [IW-1:0]  model_mem [0:15];
  int             checks = 0;
  int             errors = 0;
  int             idx;

  instr_fetch_if #(.IMW(IMW), .IW(IW)) bus ();

  instr_fetch #(.IMW(IMW), .IW(IW)) dut (
    .clk       (clk),
    .start     (start),
    .run       (run),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .bus       (bus.slave),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a);
    sb_q.push_back('{pc: IMW'(a), instr: model_mem[IMW'(a)]});
  endtask

  task automatic load_word(input int a, input logic [IW-1:0] d);
    load_en   = 1'b1;
    load_addr = IMW'(a);
    load_data = d;
    model_mem[IMW'(a)] = d;
    step;
    load_en = 1'b0;
  endtask

  task automatic pulse_run;
    run = 1'b1;
    step;
    run = 1'b0;
  endtask

  // Issue one fetch address, waiting a bounded number of cycles for pc_ready.
  task automatic issue(input int a);
    bit got;
    got = 1'b0;
    bus.pc_valid = 1'b1;
    bus.pc_in    = IMW'(a);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.pc_ready) begin
        got = 1'b1;
        push_exp(a);
      end
      step;
    end
    bus.pc_valid = 1'b0;
    check("issue_accept", 32'(got), 32'd1);
  endtask

  // Wait (bounded) for the scoreboard to empty.
  task automatic drain;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin
      step;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    step;
  endtask

  // Monitor: compare every word decode consumes against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: pc 0x%0h instr 0x%0h with nothing expected",
                   bus.pc_out, bus.instr_out);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_pc", 32'(bus.pc_out), 32'(e.pc));
          check("out_instr", bus.instr_out, e.instr);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    start = 1'b1; run = 1'b0; load_en = 1'b0;
    load_addr = '0; load_data = '0;
    bus.pc_valid = 1'b0; bus.pc_in = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    step; step;
    start = 1'b0;
    @(negedge clk);
    check("rst_pc_ready",  32'(bus.pc_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr_out", bus.instr_out,      32'd0);
    check("rst_pc_out",    32'(bus.pc_out),    32'd0);
    check("rst_halted",    32'(halted),        32'd0);
    step;

    // Program: mem[i] = 0x11 * (i+1) for i = 0..7.
    for (int i = 0; i < 8; i++) load_word(i, IW'(32'h11 * (i + 1)));
    pulse_run;
    @(negedge clk);
    check("run_pc_ready", 32'(bus.pc_ready), 32'd1);
    step;

    // Back-to-back fetch 0..3: out_valid two cycles after the first accept.
    for (int k = 0; k < 7; k++) begin
      bus.pc_valid = (k < 4);
      bus.pc_in    = IMW'(k);
      @(negedge clk);
      check("t1_out_valid", 32'(bus.out_valid), 32'(k >= 2 && k <= 5));
      if (k < 4) begin
        check("t1_pc_ready", 32'(bus.pc_ready), 32'd1);
        if (bus.pc_ready) push_exp(k);
      end
      step;
    end
    drain;

    // Stall: out_ready low for three cycles with both stages full.
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      bus.out_ready = !(k >= 2 && k <= 4);
      bus.pc_valid  = (idx < 4);
      bus.pc_in     = IMW'(4 + idx);
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        check("stall_pc_ready",  32'(bus.pc_ready),  32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_pc_out",    32'(bus.pc_out),    32'd4);
        check("stall_instr_out", bus.instr_out,      32'h55);
      end
      if (bus.pc_valid && bus.pc_ready) begin
        push_exp(4 + idx);
        idx++;
      end
      step;
    end
    bus.pc_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stall_all_accepted", 32'(idx), 32'd4);
    drain;

    // Flush with both stages full, then fetch address 7.
    bus.out_ready = 1'b0;
    bus.pc_valid  = 1'b1;
    bus.pc_in     = 4'd0;
    @(negedge clk); step;
    bus.pc_in = 4'd1;
    @(negedge clk); step;
    bus.pc_valid = 1'b0;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
    check("flush_pc_ready",  32'(bus.pc_ready),  32'd0);
    step;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.pc_valid  = 1'b1;
    bus.pc_in     = 4'd7;
    @(negedge clk);
    check("flush_post_valid", 32'(bus.out_valid), 32'd0);
    check("flush_accept7",    32'(bus.pc_ready),  32'd1);
    if (bus.pc_ready) push_exp(7);
    step;
    bus.pc_valid = 1'b0;
    @(negedge clk);
    check("flush_gap_valid", 32'(bus.out_valid), 32'd0);
    step;
    @(negedge clk);
    check("flush_7_valid", 32'(bus.out_valid), 32'd1);
    step;
    drain;

    // load_en during RUN is ignored; mem[0] still holds 0x11.
    load_en = 1'b1; load_addr = 4'd0; load_data = 32'hDEAD;
    step;
    load_en = 1'b0;
    issue(0);
    drain;

    // start with both stages full returns to IDLE with the pipeline cleared.
    bus.out_ready = 1'b0;
    bus.pc_valid  = 1'b1;
    bus.pc_in     = 4'd2;
    @(negedge clk); step;
    bus.pc_in = 4'd3;
    @(negedge clk); step;
    bus.pc_valid = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    check("start_pre_valid", 32'(bus.out_valid), 32'd1);
    step;
    start = 1'b0;
    @(negedge clk);
    check("start_out_valid", 32'(bus.out_valid), 32'd0);
    check("start_pc_ready",  32'(bus.pc_ready),  32'd0);
    check("start_pc_out",    32'(bus.pc_out),    32'd0);
    check("start_halted",    32'(halted),        32'd0);
    step;
    bus.out_ready = 1'b1;
    pulse_run;
    issue(1);
    drain;

    // HALT opcode at address 2.
    start = 1'b1;
    step;
    start = 1'b0;
    load_word(2, 32'hFFFF_FFFF);
    pulse_run;
    for (int k = 0; k < 7; k++) begin
      bus.pc_valid = (k < 4);
      bus.pc_in    = IMW'(k);
      @(negedge clk);
      if (k < 4) begin
        check("halt_pc_ready_pre", 32'(bus.pc_ready), 32'd1);
        if (bus.pc_ready && !(HALT_EN && k == 3)) push_exp(k);
      end
      if (k == 4 || k == 6) begin
        check("halt_halted",   32'(halted),       32'(HALT_EN));
        check("halt_pc_ready", 32'(bus.pc_ready), 32'(!HALT_EN));
      end
      if (k == 4) begin
        check("halt_word_pc",    32'(bus.pc_out),    32'd2);
        check("halt_word_valid", 32'(bus.out_valid), 32'd1);
      end
      if (k == 5) begin
        check("halt_addr3_valid", 32'(bus.out_valid), 32'(!HALT_EN));
      end
      step;
    end
    bus.pc_valid = 1'b0;
    drain;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch
